// File: rtl/sb_alloc.sv
// sb_alloc: in-order store-buffer ID allocator with commit tracking, oldest-first drain and flush recovery.
package config_pkg;
    typedef struct packed {
        int unsigned INSTR_PER_FETCH;
    } cfg_t;
    localparam cfg_t EmptyCfg = '{INSTR_PER_FETCH: 4};
endpackage

module sb_alloc #(
    parameter config_pkg::cfg_t Cfg = config_pkg::EmptyCfg,
    parameter int unsigned SB_DEPTH = 16,
    parameter int unsigned SB_IDX_WIDTH = $clog2(SB_DEPTH),
    localparam int unsigned W = Cfg.INSTR_PER_FETCH,
    localparam int unsigned CW = $clog2(W + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [W-1:0]                     alloc_req_i,
    input  logic                             alloc_fire_i,
    output logic                             alloc_ready_o,
    output logic [W-1:0][SB_IDX_WIDTH-1:0]   alloc_id_o,
    input  logic [CW-1:0]                    commit_cnt_i,
    output logic                             drain_valid_o,
    output logic [SB_IDX_WIDTH-1:0]          drain_id_o,
    input  logic                             drain_ready_i,
    input  logic                             flush_i,
    output logic [SB_IDX_WIDTH:0]            free_cnt_o,
    output logic                             empty_o
);
    localparam int unsigned PW = SB_IDX_WIDTH + 1;

    logic [PW-1:0] r_head, r_cmt, r_tail;
    logic [PW-1:0] w_used, w_n_req, w_cmt_next, w_tail_next;

    // Each requesting lane takes tail plus the number of older requesting lanes.
    always_comb begin
        w_n_req = '0;
        for (int i = 0; i < W; i++) begin
            alloc_id_o[i] = alloc_req_i[i] ? r_tail[SB_IDX_WIDTH-1:0] + w_n_req[SB_IDX_WIDTH-1:0] : '0;
            w_n_req = w_n_req + PW'(alloc_req_i[i]);
        end
    end

    assign w_used        = r_tail - r_head;
    assign free_cnt_o    = PW'(SB_DEPTH) - w_used;
    assign empty_o       = (w_used == '0);
    assign alloc_ready_o = (w_n_req <= free_cnt_o);
    assign drain_valid_o = (r_head != r_cmt);
    assign drain_id_o    = r_head[SB_IDX_WIDTH-1:0];
    assign w_cmt_next    = r_cmt + PW'(commit_cnt_i);
    // Flush keeps committed stores, including those committed this same cycle.
    assign w_tail_next   = flush_i ? w_cmt_next :
                           (alloc_fire_i && alloc_ready_o) ? r_tail + w_n_req : r_tail;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_head <= '0;
            r_cmt  <= '0;
            r_tail <= '0;
        end else begin
            r_head <= r_head + PW'(drain_valid_o && drain_ready_i);
            r_cmt  <= w_cmt_next;
            r_tail <= w_tail_next;
        end
    end

    a_commit_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        PW'(commit_cnt_i) <= r_tail - r_cmt);
endmodule
